// File: rtl/anubis_round_ctrl.sv
// Round sequencer for the iterative ANUBIS datapath: whitening load, ROUNDS-1 full
// rounds, one final round without Theta, then hands the ciphertext to the host.
module anubis_round_ctrl #(
    parameter int ROUNDS = 12,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             key_ready,
    output logic             dp_load,
    output logic             dp_round_en,
    output logic             dp_final,
    output logic [CNT_W-1:0] round_idx,
    output logic             ks_advance,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Index of the last full round; the final (Theta-less) round follows it.
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDX_ZERO = CNT_W'(0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             load_s, round_s, final_s;

    // State and round-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state decode; enables only fire on a cycle the key schedule is ready.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        round_s = 1'b0;
        final_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (key_ready) begin
                    load_s  = 1'b1;
                    idx_d   = IDX_ONE;
                    state_d = S_ROUND;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_ROUND: begin
                if (key_ready) begin
                    round_s = 1'b1;
                    idx_d   = idx_q + IDX_ONE;
                    if (idx_q == LAST_RND) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_ROUND;
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_FINAL: begin
                if (key_ready) begin
                    final_s = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FINAL;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                    idx_d   = IDX_ZERO;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    assign dp_load     = load_s;
    assign dp_round_en = round_s;
    assign dp_final    = final_s;
    assign ks_advance  = load_s | round_s | final_s;
    assign round_idx   = idx_q;
    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done_valid  = (state_q == S_DONE);

endmodule
